// File: rtl/duty_button_conditioner.sv
// Two-button front end for the PWM duty controller: sync, debounce,
// press/hold auto-repeat and a lockout that blocks simultaneous steps.
module duty_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 20_000_000,
  parameter int CNT_W           = 28
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_inc_raw,
  input  logic btn_dec_raw,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic inc_level,
  output logic dec_level
);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } state_t;

  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_MAX = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_MAX = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO   = '0;

  // Channel 0 is increase, channel 1 is decrease.
  logic [1:0]       raw;
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       lvl;
  logic [1:0]       lvl_d;
  logic [1:0]       fire;
  logic [1:0]       pulse;
  logic             lock;
  logic [CNT_W-1:0] dcnt    [2];
  logic [CNT_W-1:0] rcnt_q  [2];
  logic [CNT_W-1:0] rcnt_d  [2];
  state_t           state_q [2];
  state_t           state_d [2];

  assign raw  = {btn_dec_raw, btn_inc_raw};
  assign lock = lvl[0] & lvl[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      lvl   <= '0;
      lvl_d <= '0;
      pulse <= '0;
      for (int i = 0; i < 2; i++) begin
        dcnt[i]    <= ZERO;
        rcnt_q[i]  <= ZERO;
        state_q[i] <= IDLE;
      end
    end else begin
      s1    <= raw;
      s2    <= s1;
      lvl_d <= lvl;
      // Suppressed events are dropped; the timers keep their grid.
      pulse <= fire & {2{~lock}};
      for (int i = 0; i < 2; i++) begin
        rcnt_q[i]  <= rcnt_d[i];
        state_q[i] <= state_d[i];
        if (s2[i] == lvl[i]) begin
          dcnt[i] <= ZERO;
        end else if (dcnt[i] == DB_MAX) begin
          lvl[i]  <= s2[i];
          dcnt[i] <= ZERO;
        end else begin
          dcnt[i] <= dcnt[i] + ONE;
        end
      end
    end
  end

  always_comb begin
    fire = '0;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      rcnt_d[i]  = rcnt_q[i];
      if (!lvl[i]) begin
        state_d[i] = IDLE;
        rcnt_d[i]  = ZERO;
      end else begin
        unique case (state_q[i])
          IDLE: begin
            if (!lvl_d[i]) begin
              fire[i]    = 1'b1;
              rcnt_d[i]  = ZERO;
              state_d[i] = DELAY;
            end
          end
          DELAY: begin
            if (rcnt_q[i] == RD_MAX) begin
              fire[i]    = 1'b1;
              rcnt_d[i]  = ZERO;
              state_d[i] = REPEAT;
            end else begin
              rcnt_d[i] = rcnt_q[i] + ONE;
            end
          end
          REPEAT: begin
            if (rcnt_q[i] == RP_MAX) begin
              fire[i]   = 1'b1;
              rcnt_d[i] = ZERO;
            end else begin
              rcnt_d[i] = rcnt_q[i] + ONE;
            end
          end
          default: begin
            state_d[i] = IDLE;
            rcnt_d[i]  = ZERO;
          end
        endcase
      end
    end
  end

  assign inc_pulse = pulse[0];
  assign dec_pulse = pulse[1];
  assign inc_level = lvl[0];
  assign dec_level = lvl[1];

endmodule

// File: tb/tb_duty_button_conditioner.sv
// Directed bench for duty_button_conditioner with short timer values.
// Pulse times are edge numbers counted from the last mark() call.
module tb_duty_button_conditioner;

  logic clk;
  logic reset;
  logic btn_inc_raw;
  logic btn_dec_raw;
  logic inc_pulse;
  logic dec_pulse;
  logic inc_level;
  logic dec_level;

  int n_run;
  int n_fail;
  int t;
  int inc_at[$];
  int dec_at[$];

  duty_button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_inc_raw(btn_inc_raw),
    .btn_dec_raw(btn_dec_raw),
    .inc_pulse  (inc_pulse),
    .dec_pulse  (dec_pulse),
    .inc_level  (inc_level),
    .dec_level  (dec_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
    if (inc_pulse) inc_at.push_back(t);
    if (dec_pulse) dec_at.push_back(t);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic mark();
    t = 0;
    inc_at.delete();
    dec_at.delete();
  endtask

  function automatic int inc_n(input int i);
    return (i < inc_at.size()) ? inc_at[i] : -1;
  endfunction

  function automatic int dec_n(input int i);
    return (i < dec_at.size()) ? dec_at[i] : -1;
  endfunction

  int exp3[7] = '{7, 17, 22, 27, 32, 37, 42};
  int exp4[4] = '{7, 37, 42, 47};

  initial begin
    n_run       = 0;
    n_fail      = 0;
    t           = 0;
    reset       = 1'b1;
    btn_inc_raw = 1'b0;
    btn_dec_raw = 1'b0;
    run(2);
    check("rst_outs", {inc_pulse, dec_pulse, inc_level, dec_level}, 0);
    reset = 1'b0;
    run(3);
    check("post_rst_outs", {inc_pulse, dec_pulse, inc_level, dec_level}, 0);

    // 1: clean press held 8 cycles
    mark();
    btn_inc_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 5) check("t1_lvl_e5", inc_level, 0);
      if (k == 6) check("t1_lvl_e6", inc_level, 1);
    end
    btn_inc_raw = 1'b0;
    run(20);
    check("t1_inc_cnt", inc_at.size(), 1);
    check("t1_inc_t", inc_n(0), 7);
    check("t1_dec_cnt", dec_at.size(), 0);
    check("t1_lvl_rel", inc_level, 0);

    // 2: bouncing decrease button
    mark();
    for (int k = 0; k < 4; k++) begin
      btn_dec_raw = (k % 2 == 0);
      run(2);
    end
    btn_dec_raw = 1'b1;
    run(8);
    btn_dec_raw = 1'b0;
    run(20);
    check("t2_dec_cnt", dec_at.size(), 1);
    check("t2_dec_t", dec_n(0), 15);
    check("t2_inc_cnt", inc_at.size(), 0);
    check("t2_lvl_rel", dec_level, 0);

    // 3: long hold with auto-repeat
    mark();
    btn_inc_raw = 1'b1;
    run(40);
    btn_inc_raw = 1'b0;
    run(25);
    check("t3_inc_cnt", inc_at.size(), 7);
    for (int k = 0; k < 7; k++)
      check($sformatf("t3_inc_t%0d", k), inc_n(k), exp3[k]);
    check("t3_lvl_rel", inc_level, 0);

    // 4: lockout while both held
    mark();
    btn_inc_raw = 1'b1;
    run(10);
    btn_dec_raw = 1'b1;
    run(10);
    check("t4_both_lvl", {inc_level, dec_level}, 3);
    run(10);
    btn_dec_raw = 1'b0;
    run(14);
    btn_inc_raw = 1'b0;
    run(20);
    check("t4_inc_cnt", inc_at.size(), 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("t4_inc_t%0d", k), inc_n(k), exp4[k]);
    check("t4_dec_cnt", dec_at.size(), 0);

    // 5: reset while in repeat
    mark();
    btn_inc_raw = 1'b1;
    run(22);
    check("t5_pulse_pre", inc_pulse, 1);
    reset = 1'b1;
    #1;
    check("t5_rst_outs", {inc_pulse, dec_pulse, inc_level, dec_level}, 0);
    run(2);
    check("t5_rst_hold", {inc_pulse, dec_pulse, inc_level, dec_level}, 0);
    reset = 1'b0;
    mark();
    run(9);
    btn_inc_raw = 1'b0;
    run(15);
    check("t5_inc_cnt", inc_at.size(), 1);
    check("t5_inc_t", inc_n(0), 7);

    // 6: short glitch is ignored
    mark();
    btn_inc_raw = 1'b1;
    run(3);
    btn_inc_raw = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (k == 3) check("t6_lvl", inc_level, 0);
    end
    check("t6_inc_cnt", inc_at.size(), 0);
    check("t6_lvl_end", inc_level, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
